// File: rtl/hamming_secded_decoder.sv
// Two-stage SEC-DED decoder for 16-bit extended Hamming codewords carrying 11 data bits.
// Define HAM_ERR_CNT_EN to build the saturating corrected/uncorrected error counters.
module hamming_secded_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic [3:0]       out_syn,
    output logic             out_sec,
    output logic             out_ded,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    // Codeword position of each data bit, d1 first.
    localparam int DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic        en1;
    logic        en2;
    logic        v1_reg;
    logic        v2_reg;
    logic [10:0] data1_reg;
    logic [3:0]  syn1_reg;
    logic        par1_reg;
    logic [10:0] data2_reg;
    logic [3:0]  syn2_reg;
    logic        sec2_reg;
    logic        ded2_reg;
    logic [3:0]  syn_in;
    logic [10:0] data_in;
    logic [10:0] data_fix;
    logic        sec_next;
    logic        ded_next;

    assign en2      = !v2_reg || out_ready;
    assign en1      = !v1_reg || en2;
    assign in_ready = en1 && reset;

    assign syn_in[3] = ^in_cw[15:8];
    assign syn_in[2] = ^{in_cw[15:12], in_cw[7:4]};
    assign syn_in[1] = ^{in_cw[15:14], in_cw[11:10], in_cw[7:6], in_cw[3:2]};
    assign syn_in[0] = ^{in_cw[15], in_cw[13], in_cw[11], in_cw[9],
                         in_cw[7], in_cw[5], in_cw[3], in_cw[1]};

    // Only data positions are carried forward; a syndrome pointing at a parity
    // bit needs no data flip, so the parity bits themselves are never stored.
    generate
        for (genvar gi = 0; gi < 11; gi++) begin : g_data
            assign data_in[gi]  = in_cw[DATA_POS[gi]];
            assign data_fix[gi] = data1_reg[gi] ^ (par1_reg && (syn1_reg == 4'(DATA_POS[gi])));
        end
    endgenerate

    assign sec_next = par1_reg;
    assign ded_next = !par1_reg && (syn1_reg != 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_reg    <= 1'b0;
            data1_reg <= '0;
            syn1_reg  <= '0;
            par1_reg  <= 1'b0;
            v2_reg    <= 1'b0;
            data2_reg <= '0;
            syn2_reg  <= '0;
            sec2_reg  <= 1'b0;
            ded2_reg  <= 1'b0;
        end else begin
            if (en1) begin
                v1_reg    <= in_valid;
                data1_reg <= data_in;
                syn1_reg  <= syn_in;
                par1_reg  <= ^in_cw;
            end
            if (en2) begin
                v2_reg    <= v1_reg;
                data2_reg <= data_fix;
                syn2_reg  <= syn1_reg;
                sec2_reg  <= sec_next;
                ded2_reg  <= ded_next;
            end
        end
    end

    assign out_valid = v2_reg;
    assign out_data  = data2_reg;
    assign out_syn   = syn2_reg;
    assign out_sec   = sec2_reg;
    assign out_ded   = ded2_reg;

`ifdef HAM_ERR_CNT_EN
    logic             xfer;
    logic [CNT_W-1:0] corr_reg;
    logic [CNT_W-1:0] uncorr_reg;

    assign xfer = v2_reg && out_ready;

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk) begin
        if (!reset || cnt_clr) begin
            corr_reg   <= '0;
            uncorr_reg <= '0;
        end else begin
            if (xfer && sec2_reg && (corr_reg != '1))
                corr_reg <= corr_reg + CNT_W'(1);
            if (xfer && ded2_reg && (uncorr_reg != '1))
                uncorr_reg <= uncorr_reg + CNT_W'(1);
        end
    end

    assign corr_cnt   = corr_reg;
    assign uncorr_cnt = uncorr_reg;
`else
    logic cnt_clr_unused;

    assign cnt_clr_unused = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder; counter expectations follow HAM_ERR_CNT_EN.
module tb_hamming_secded_decoder;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        sec;
        logic        ded;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_cw;
    logic             out_valid;
    logic             out_ready;
    logic [10:0]      out_data;
    logic [3:0]       out_syn;
    logic             out_sec;
    logic             out_ded;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    exp_t             sb[$];
    exp_t             e;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_out = 0;
    logic [CNT_W-1:0] exp_corr = '0;
    logic [CNT_W-1:0] exp_uncorr = '0;
    logic             acc;
    logic             dlv;
    logic             obs_valid;
    exp_t             obs;

    hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
        .out_sec(out_sec), .out_ded(out_ded), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    // Reference decode from the Hamming definition: syndrome = XOR of set-bit positions.
    function automatic exp_t model(input logic [15:0] cw);
        exp_t        r;
        logic [3:0]  s;
        logic [15:0] c;
        int          k;
        r = '0;
        s = '0;
        for (int i = 1; i < 16; i++) if (cw[i]) s ^= 4'(i);
        c = cw;
        if (^cw) begin
            r.sec = 1'b1;
            if (s != 4'd0) c[s] = ~c[s];
        end else if (s != 4'd0) begin
            r.ded = 1'b1;
        end
        r.syn = s;
        k = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                r.data[k] = c[i];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        logic [3:0]  s;
        int          k;
        cw = '0;
        s  = '0;
        k  = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                if (d[k]) s ^= 4'(i);
                k++;
            end
        end
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    // One clock: sample handshakes mid-cycle, keep the scoreboard and counter model, then cross the edge.
    task automatic step();
        @(negedge clk);
        obs_valid = out_valid;
        obs       = '{out_data, out_syn, out_sec, out_ded};
        acc       = reset && in_valid && in_ready;
        dlv       = reset && out_valid && out_ready;
        if (!reset) begin
            sb.delete();
            exp_corr   = '0;
            exp_uncorr = '0;
        end else begin
            if (acc) sb.push_back(model(in_cw));
            if (dlv) begin
                n_out++;
                $display("out #%0d data=%03h syn=%0d sec=%0b ded=%0b", n_out, obs.data, obs.syn, obs.sec, obs.ded);
            end
`ifdef HAM_ERR_CNT_EN
            if (cnt_clr) begin
                exp_corr   = '0;
                exp_uncorr = '0;
            end else if (dlv) begin
                if (obs.sec && exp_corr != '1) exp_corr++;
                if (obs.ded && exp_uncorr != '1) exp_uncorr++;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_cw = 16'hFFBF; out_ready = 1'b1; cnt_clr = 1'b0;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        n_cmp++; if ({out_data, out_syn, out_sec, out_ded} !== 17'd0) begin n_bad++; $display("FAIL reset_fields got=%05h want=0", {out_data, out_syn, out_sec, out_ded}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        n_cmp++; if ({corr_cnt, uncorr_cnt} !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", corr_cnt, uncorr_cnt); end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got=%0b want=1", in_ready); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1; in_valid = 1'b1; in_cw = 16'hFFFF;
        step();
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL lat_accept got=%0b want=1", acc); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL lat_cycle1 got=%0b want=0", obs_valid); end
        step();
        n_cmp++; if (obs_valid !== 1'b1) begin n_bad++; $display("FAIL lat_cycle2 got=%0b want=1", obs_valid); end
        if (dlv) begin
            e = (sb.size() != 0) ? sb.pop_front() : 'x;
            n_cmp++; if (obs !== e || obs !== {11'h7FF, 4'd0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL lat_word got=%05h want=%05h", obs, e); end
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vec [4];
        exp_t        want [4];
        int          ni;
        int          no;
        vec[0] = 16'hFFFF; want[0] = '{11'h7FF, 4'd0, 1'b0, 1'b0};
        vec[1] = 16'hFFBF; want[1] = '{11'h7FF, 4'd6, 1'b1, 1'b0};
        vec[2] = 16'hFFFE; want[2] = '{11'h7FF, 4'd0, 1'b1, 1'b0};
        vec[3] = 16'hFFD7; want[3] = '{11'h7FC, 4'd6, 1'b0, 1'b1};
        ni = 0; no = 0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && no < 4; cyc++) begin
            in_valid = (ni < 4);
            in_cw    = vec[ni < 4 ? ni : 3];
            step();
            if (acc) ni++;
            if (dlv) begin
                e = (sb.size() != 0) ? sb.pop_front() : 'x;
                n_cmp++; if (obs !== want[no] || obs !== e) begin n_bad++; $display("FAIL vec%0d got=%05h want=%05h", no, obs, want[no]); end
                no++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (no != 4) begin n_bad++; $display("FAIL vec_count got=%0d want=4", no); end
        n_cmp++; if (corr_cnt !== exp_corr || uncorr_cnt !== exp_uncorr) begin n_bad++; $display("FAIL vec_cnt got=%0d/%0d want=%0d/%0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [4];
        exp_t        hold;
        logic        held;
        int          ni;
        int          no;
        for (int i = 0; i < 4; i++) w[i] = encode(11'($urandom));
        w[1][9] = ~w[1][9];
        ni = 0; no = 0; held = 1'b0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = 1'b1;
            in_cw    = w[ni < 4 ? ni : 3];
            step();
            if (acc) ni++;
            if (obs_valid && held) begin
                n_cmp++; if (obs !== hold) begin n_bad++; $display("FAIL bp_stable got=%05h want=%05h", obs, hold); end
            end
            if (obs_valid && !held) begin hold = obs; held = 1'b1; end
        end
        n_cmp++; if (ni != 2) begin n_bad++; $display("FAIL bp_accepted got=%0d want=2", ni); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && no < 4; cyc++) begin
            in_valid = (ni < 4);
            in_cw    = w[ni < 4 ? ni : 3];
            step();
            if (acc) ni++;
            if (dlv) begin
                e = (sb.size() != 0) ? sb.pop_front() : 'x;
                n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL bp_word%0d got=%05h want=%05h", no, obs, e); end
                no++;
            end
        end
        in_valid = 1'b0;
        step(); step();
        n_cmp++; if (no != 4 || sb.size() != 0 || dlv) begin n_bad++; $display("FAIL bp_count got=%0d left=%0d want=4/0", no, sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cw;
        int          ni;
        int          no;
        int          b1;
        ni = 0; no = 0;
        cw = encode(11'($urandom));
        for (int cyc = 0; cyc < 1000 && no < 80; cyc++) begin
            in_valid  = (ni < 80) && ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(9, 0) < 7);
            cnt_clr   = ($urandom_range(19, 0) == 0);
            in_cw     = cw;
            step();
            if (acc) begin
                ni++;
                cw = encode(11'($urandom));
                b1 = $urandom_range(15, 0);
                case ($urandom_range(2, 0))
                    1: cw[b1] = ~cw[b1];
                    2: begin cw[b1] = ~cw[b1]; cw[(b1 + $urandom_range(15, 1)) % 16] ^= 1'b1; end
                    default: ;
                endcase
            end
            if (dlv) begin
                e = (sb.size() != 0) ? sb.pop_front() : 'x;
                n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL rnd_word%0d got=%05h want=%05h", no, obs, e); end
                no++;
            end
            n_cmp++; if (corr_cnt !== exp_corr || uncorr_cnt !== exp_uncorr) begin n_bad++; $display("FAIL rnd_cnt got=%0d/%0d want=%0d/%0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr); end
        end
        in_valid = 1'b0; cnt_clr = 1'b0;
        n_cmp++; if (no != 80) begin n_bad++; $display("FAIL rnd_count got=%0d want=80", no); end
    endtask

    task automatic test_counters();
        int ni;
        int no;
        reset = 1'b0; step(); reset = 1'b1;
        out_ready = 1'b1; in_cw = 16'hFFBF; ni = 0; no = 0;
        for (int cyc = 0; cyc < 30 && no < 5; cyc++) begin
            in_valid = (ni < 5);
            step();
            if (acc) ni++;
            if (dlv) begin
                e = (sb.size() != 0) ? sb.pop_front() : 'x;
                n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL sat_word%0d got=%05h want=%05h", no, obs, e); end
                no++;
            end
        end
        in_valid = 1'b0;
`ifdef HAM_ERR_CNT_EN
        n_cmp++; if (corr_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_corr got=%0d want=3", corr_cnt); end
`else
        n_cmp++; if (corr_cnt !== 2'd0) begin n_bad++; $display("FAIL tied_corr got=%0d want=0", corr_cnt); end
`endif
        in_valid = 1'b1; step(); in_valid = 1'b0;
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_cmp++; if (dlv !== 1'b1 || !obs.sec) begin n_bad++; $display("FAIL clr_xfer got=%0b want=1", dlv); end
        if (dlv) void'(sb.pop_front());
        n_cmp++; if (corr_cnt !== 2'd0 || corr_cnt !== exp_corr) begin n_bad++; $display("FAIL clr_priority got=%0d want=0", corr_cnt); end
        // Build up counts again, then reset with both stages full.
        in_valid = 1'b1; in_cw = 16'hFFD7;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got=%0b want=0", out_valid); end
        n_cmp++; if ({corr_cnt, uncorr_cnt} !== '0) begin n_bad++; $display("FAIL mid_reset_cnt got=%0d/%0d want=0/0", corr_cnt, uncorr_cnt); end
        in_valid = 1'b0; reset = 1'b1;
        step(); step(); step();
        n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL dropped_word got=%0b want=0", obs_valid); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
